// File: rtl/npu_axi_rd_dma.sv
// AXI read DMA: splits a command into 4 KB-safe AR bursts and downsizes R beats into an OUT_WIDTH stream.
// Optional macro NPU_RD_DMA_RESP_CHECK_EN adds a sticky err output for non-OKAY read responses.
module npu_axi_rd_dma #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 256,
  parameter int OUT_WIDTH   = 128,
  parameter int ID_WIDTH    = 10,
  parameter int MAX_BURST   = 64,
  parameter int OUTSTANDING = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef NPU_RD_DMA_RESP_CHECK_EN
  output logic                  err,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int RATIO    = DATA_WIDTH / OUT_WIDTH;
  localparam int LANE_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int SIZE_LOG = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W    = $clog2(OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [LEN_WIDTH-1:0]  rem_p0;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] hold_data_p1;
  logic                  vld_p1;
  logic [LANE_W-1:0]     lane_p1;
  logic [8:0]            blen;
  logic                  ar_fire, r_fire, rlast_fire, lane_fire, last_lane;

  // Burst length saturated by remaining beats, MAX_BURST and the distance to the next 4 KB page.
  function automatic logic [8:0] burst_len_f(input logic [LEN_WIDTH-1:0] rem,
                                             input logic [11:0] page_off);
    logic [31:0] lim;
    logic [31:0] to_4k;
    lim   = (32'(rem) < 32'(MAX_BURST)) ? 32'(rem) : 32'(MAX_BURST);
    to_4k = (32'h1000 - {20'd0, page_off}) >> SIZE_LOG;
    if (to_4k < lim) lim = to_4k;
    return 9'(lim);
  endfunction

  assign blen       = burst_len_f(rem_p0, addr_p0[11:0]);
  assign m_arid     = '0;
  assign m_araddr   = addr_p0;
  assign m_arlen    = 8'(blen - 9'd1);
  assign m_arsize   = 3'(SIZE_LOG);
  assign m_arburst  = 2'b01;
  assign ar_fire    = m_arvalid && m_arready;
  assign r_fire     = m_rvalid && m_rready;
  assign rlast_fire = r_fire && m_rlast;
  assign out_valid  = vld_p1;
  assign last_lane  = (lane_p1 == LANE_W'(RATIO - 1));
  assign lane_fire  = vld_p1 && out_ready;
  assign out_data   = OUT_WIDTH'(hold_data_p1 >> (32'(lane_p1) * OUT_WIDTH));
  // Accept a new beat as soon as the last lane of the current one leaves.
  assign m_rready   = (state != IDLE) && (!vld_p1 || (lane_fire && last_lane));
  assign busy       = (state != IDLE) && !done;

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    m_arvalid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (rem_p0 == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          m_arvalid = (cnt != CNT_W'(OUTSTANDING));
          if (m_arvalid && m_arready && (32'(blen) == 32'(rem_p0))) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((cnt == '0) && lane_fire && last_lane) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case ({ar_fire, rlast_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Stage p0: command address/beat bookkeeping
  always_ff @(posedge clk) begin
    if (cmd_ready && cmd_valid) begin
      addr_p0 <= cmd_addr;
      rem_p0  <= cmd_beats;
    end else if (ar_fire) begin
      addr_p0 <= addr_p0 + ADDR_WIDTH'({23'd0, blen} << SIZE_LOG);
      rem_p0  <= rem_p0 - LEN_WIDTH'(blen);
    end
  end

  // Stage p1: R beat holding register and lane selector
  always_ff @(posedge clk) begin
    if (r_fire) hold_data_p1 <= m_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      lane_p1 <= '0;
    end else if (r_fire) begin
      vld_p1  <= 1'b1;
      lane_p1 <= '0;
    end else if (lane_fire) begin
      if (last_lane) begin
        vld_p1  <= 1'b0;
        lane_p1 <= '0;
      end else begin
        lane_p1 <= lane_p1 + LANE_W'(1);
      end
    end
  end

`ifdef NPU_RD_DMA_RESP_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (r_fire && (m_rresp != 2'b00)) err <= 1'b1;
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^m_rresp;
`endif

endmodule

// File: tb/tb_npu_axi_rd_dma.sv
// Directed bench for npu_axi_rd_dma with a background AXI slave and stream monitor.
// Define NPU_RD_DMA_RESP_CHECK_EN to also exercise the err output.
module tb_npu_axi_rd_dma;
  logic         clk;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [63:0]  cmd_addr;
  logic [15:0]  cmd_beats;
  logic [9:0]   m_arid;
  logic [63:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic         m_arvalid, m_arready;
  logic [255:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast, m_rvalid, m_rready;
  logic [127:0] out_data;
  logic         out_valid, out_ready;
  logic         busy, done;
`ifdef NPU_RD_DMA_RESP_CHECK_EN
  logic         err;
`endif

  npu_axi_rd_dma #(
    .ADDR_WIDTH(64), .DATA_WIDTH(256), .OUT_WIDTH(128), .ID_WIDTH(10),
    .MAX_BURST(64), .OUTSTANDING(8), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef NPU_RD_DMA_RESP_CHECK_EN
    .err(err),
`endif
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;
  int q_len[$];
  int bidx, rbeat, out_idx, done_cnt, data_err, stab_err, osd, osd_max, ar_n, cyc, err_beat;
  logic [63:0]  ar_addr_log[16];
  int           ar_len_log[16];
  bit           r_en, manual;
  int           ar_mode, or_mode;
  logic         man_rvalid, man_rlast;
  logic [255:0] man_rdata;
  bit           p_ar, p_r, p_rlast, p_out, p_rst, h_pend;
  int           p_arlen;
  logic [63:0]  h_addr;
  logic [7:0]   h_len;
  logic [127:0] pat_a, pat_b;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // AXI slave + monitor: samples handshakes just before each rising edge, drives just after it.
  initial begin
    m_arready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    out_ready = 1'b1; cyc = 0; h_pend = 0; h_addr = '0; h_len = '0;
    forever begin
      @(negedge clk); #3;
      p_ar = m_arvalid && m_arready; p_r = m_rvalid && m_rready; p_rlast = m_rlast;
      p_out = out_valid && out_ready; p_rst = rst; p_arlen = int'(m_arlen) + 1;
      if (done) done_cnt++;
      if (p_out) begin
        if (!manual && out_data !== 128'(out_idx)) data_err++;
        out_idx++;
      end
      if (p_ar) begin
        if (ar_n < 16) begin
          ar_addr_log[ar_n] = m_araddr;
          ar_len_log[ar_n]  = int'(m_arlen);
        end
        ar_n++;
      end
      if (h_pend && (!m_arvalid || m_araddr !== h_addr || m_arlen !== h_len)) stab_err++;
      h_pend = m_arvalid && !m_arready && !rst; h_addr = m_araddr; h_len = m_arlen;
      if (p_rst) osd = 0;
      else begin
        if (p_ar) osd++;
        if (p_r && p_rlast) osd--;
      end
      if (osd > osd_max) osd_max = osd;
      @(posedge clk); #2;
      cyc++;
      if (p_rst) begin
        q_len.delete(); bidx = 0;
      end else begin
        if (p_ar) q_len.push_back(p_arlen);
        if (p_r && !manual && q_len.size() > 0) begin
          bidx++; rbeat++;
          if (bidx == q_len[0]) begin
            void'(q_len.pop_front());
            bidx = 0;
          end
        end
      end
      m_arready = (ar_mode == 0) ? 1'b1 : (cyc % 3 != 0);
      out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? (cyc % 2 == 0) : 1'b0;
      if (manual) begin
        m_rvalid = man_rvalid; m_rdata = man_rdata; m_rlast = man_rlast; m_rresp = 2'b00;
      end else if (r_en && q_len.size() > 0) begin
        m_rvalid = 1'b1;
        m_rdata  = {128'(2 * rbeat + 1), 128'(2 * rbeat)};
        m_rlast  = (bidx == q_len[0] - 1);
        m_rresp  = (rbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = 2'b00;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr_stats();
    q_len.delete(); bidx = 0; rbeat = 0; out_idx = 0; done_cnt = 0; data_err = 0;
    stab_err = 0; ar_n = 0; osd = 0; osd_max = 0;
  endtask

  // Leaves the caller at the falling edge of the cycle after acceptance.
  task automatic send_cmd(input logic [63:0] a, input int b);
    step();
    clr_stats();
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = 16'(b);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    chk(tag, done_cnt != 0, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    man_rvalid = 1'b0; man_rlast = 1'b0; man_rdata = '0; manual = 0; r_en = 1;
    ar_mode = 0; or_mode = 0; err_beat = -1;
    bidx = 0; rbeat = 0; out_idx = 0; done_cnt = 0; data_err = 0; stab_err = 0;
    ar_n = 0; osd = 0; osd_max = 0;
    pat_a = {8{16'hAAAA}}; pat_b = {8{16'hBBBB}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rready", m_rready, 0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
`ifdef NPU_RD_DMA_RESP_CHECK_EN
    chk("rst_err", err, 0);
`endif

    // 200 beats at 0x1000 with AR and output back-pressure
    ar_mode = 1; or_mode = 1;
    send_cmd(64'h1000, 200);
    chk("t1_busy", busy, 1);
    chk("t1_cmd_ready", cmd_ready, 0);
    chk("t1_arvalid", m_arvalid, 1);
    chk("t1_arsize", m_arsize, 5);
    chk("t1_arburst", m_arburst, 1);
    chk("t1_arid", m_arid, 0);
    wait_done("t1_done_timeout", 3000);
    chk("t1_ar_count", ar_n, 4);
    chk("t1_ar0_addr", ar_addr_log[0], 64'h1000); chk("t1_ar0_len", ar_len_log[0], 63);
    chk("t1_ar1_addr", ar_addr_log[1], 64'h1800); chk("t1_ar1_len", ar_len_log[1], 63);
    chk("t1_ar2_addr", ar_addr_log[2], 64'h2000); chk("t1_ar2_len", ar_len_log[2], 63);
    chk("t1_ar3_addr", ar_addr_log[3], 64'h2800); chk("t1_ar3_len", ar_len_log[3], 7);
    chk("t1_out_beats", out_idx, 400);
    chk("t1_data_err", data_err, 0);
    chk("t1_ar_stable", stab_err, 0);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_busy_end", busy, 0);

    // 4 KB page split
    ar_mode = 0; or_mode = 0;
    send_cmd(64'h0FC0, 4);
    wait_done("t2_done_timeout", 200);
    chk("t2_ar_count", ar_n, 2);
    chk("t2_ar0_addr", ar_addr_log[0], 64'h0FC0); chk("t2_ar0_len", ar_len_log[0], 1);
    chk("t2_ar1_addr", ar_addr_log[1], 64'h1000); chk("t2_ar1_len", ar_len_log[1], 1);
    chk("t2_out_beats", out_idx, 8);
    chk("t2_data_err", data_err, 0);

    // Outstanding limit with R withheld
    r_en = 0;
    send_cmd(64'h0, 640);
    repeat (20) @(negedge clk);
    chk("t3_ar_capped", ar_n, 8);
    chk("t3_arvalid_low", m_arvalid, 0);
    chk("t3_osd_max", osd_max, 8);
    r_en = 1;
    repeat (20) @(negedge clk);
    chk("t3_ar_still_capped", ar_n, 8);
    wait_done("t3_done_timeout", 3000);
    chk("t3_ar_count", ar_n, 10);
    chk("t3_out_beats", out_idx, 1280);
    chk("t3_data_err", data_err, 0);
    chk("t3_osd_max_end", osd_max, 8);
    chk("t3_done_once", done_cnt, 1);

    // Lane order, stall stability and rready holdoff
    manual = 1; or_mode = 2;
    send_cmd(64'h0, 1);
    step();
    man_rvalid = 1'b1; man_rdata = {pat_a, pat_b}; man_rlast = 1'b1;
    @(negedge clk);
    chk("t4_rready_empty", m_rready, 1);
    chk("t4_out_valid_pre", out_valid, 0);
    step();
    man_rvalid = 1'b0; man_rlast = 1'b0;
    @(negedge clk);
    chk("t4_latency_valid", out_valid, 1);
    chk("t4_lane0", out_data, pat_b);
    chk("t4_rready_lane0", m_rready, 0);
    step();
    @(negedge clk);
    chk("t4_lane0_stall", out_data, pat_b);
    chk("t4_valid_stall", out_valid, 1);
    chk("t4_rready_stall", m_rready, 0);
    step();
    or_mode = 0;
    @(negedge clk);
    chk("t4_lane0_fire", out_data, pat_b);
    chk("t4_rready_fire0", m_rready, 0);
    step();
    @(negedge clk);
    chk("t4_lane1", out_data, pat_a);
    chk("t4_rready_last", m_rready, 1);
    chk("t4_done", done, 1);
    chk("t4_busy_drop", busy, 0);
    step();
    @(negedge clk);
    chk("t4_done_pulse", done, 0);
    chk("t4_idle", cmd_ready, 1);
    chk("t4_out_empty", out_valid, 0);
    manual = 0;

    // Reset mid-burst, then a clean command
    send_cmd(64'h0, 200);
    repeat (10) @(negedge clk);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t5_arvalid", m_arvalid, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_rready", m_rready, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    send_cmd(64'h2000, 10);
    wait_done("t5_done_timeout", 200);
    chk("t5_ar_count", ar_n, 1);
    chk("t5_ar0_addr", ar_addr_log[0], 64'h2000); chk("t5_ar0_len", ar_len_log[0], 9);
    chk("t5_out_beats", out_idx, 20);
    chk("t5_data_err", data_err, 0);
    chk("t5_done_once", done_cnt, 1);

    // Zero-beat command
    send_cmd(64'h3000, 0);
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    chk("t6_arvalid", m_arvalid, 0);
    @(negedge clk);
    chk("t6_done_pulse", done, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_no_ar", ar_n, 0);
    chk("t6_done_once", done_cnt, 1);

`ifdef NPU_RD_DMA_RESP_CHECK_EN
    err_beat = 3;
    send_cmd(64'h0, 8);
    wait_done("t7_done_timeout", 200);
    err_beat = -1;
    chk("t7_err_set", err, 1);
    chk("t7_done_once", done_cnt, 1);
    chk("t7_data_err", data_err, 0);
    repeat (3) @(negedge clk);
    chk("t7_err_sticky", err, 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t7_err_cleared", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
